lfsr_pattern_gen: RTL and testbench

- Parametrised Fibonacci LFSR pattern generator for BIST stimulus. Successor to the fixed 3-bit, 1+x^2+x^3 generator.
- Adds run-time seed load, a programmable pattern count with a run/done FSM, enable gating and all-zero lock-up recovery.
- Sits between the test controller, which drives start/Init, and the circuit-under-test inputs, which are driven by q.

---
 rtl/lfsr_pkg.sv | 41 ++++
 rtl/lfsr_next.sv | 24 ++
 rtl/lfsr_pattern_gen.sv | 108 ++++++++++
 tb/tb_lfsr_pattern_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR pattern generator family.
// LFSR_MISR_EN (optional) turns the top into a MISR; nothing here depends on it.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lfsr_state_e;

    localparam int unsigned TAP_TABLE_W = 16;

    // Bits needed to hold any count in 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Maximal-length feedback masks; bit i set means term x^(i+1).
    function automatic logic [TAP_TABLE_W-1:0] default_taps(input int unsigned w);
        logic [TAP_TABLE_W-1:0] t;
        case (w)
            3:       t = 16'h0006;
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0829;
            13:      t = 16'h100D;
            14:      t = 16'h2015;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = 16'h0003;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational Fibonacci LFSR step; with LFSR_MISR_EN the shifted value is XORed with data_in.
module lfsr_next #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] taps,
`ifdef LFSR_MISR_EN
    input  logic [WIDTH-1:0] data_in,
`endif
    output logic [WIDTH-1:0] nxt
);

    logic fb;

    always_comb begin
        fb = ^(q & taps);
`ifdef LFSR_MISR_EN
        nxt = {q[WIDTH-2:0], fb} ^ data_in;
`else
        nxt = {q[WIDTH-2:0], fb};
`endif
    end

endmodule

// File: rtl/lfsr_pattern_gen.sv
// BIST pattern generator: seedable Fibonacci LFSR with a counted run/done FSM.
// Define LFSR_MISR_EN to add data_in and operate as a MISR (no lock-up recovery).
module lfsr_pattern_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH     = 3,
    parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0]  SEED      = '1,
    parameter int unsigned       MAX_COUNT = 255,
    parameter int unsigned       CW        = cnt_width(MAX_COUNT)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Init,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic [CW-1:0]    pat_count,
    input  logic             en,
`ifdef LFSR_MISR_EN
    input  logic [WIDTH-1:0] data_in,
`endif
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] shift_nxt;

    lfsr_next #(.WIDTH(WIDTH)) u_next (
        .q       (q_q),
        .taps    (TAPS),
`ifdef LFSR_MISR_EN
        .data_in (data_in),
`endif
        .nxt     (shift_nxt)
    );

    // Next-state: Init beats start beats normal stepping.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        lockup_d = lockup_q;
        if (Init) begin
            state_d  = ST_IDLE;
            q_d      = seed_in;
            cnt_d    = '0;
            lockup_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cnt_d    = pat_count;
                        lockup_d = 1'b0;
                        state_d  = (pat_count == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
`ifdef LFSR_MISR_EN
                        q_d = shift_nxt;
`else
                        // An all-zero register would stick forever; reload SEED instead.
                        if (q_q == '0) begin
                            q_d      = SEED;
                            lockup_d = 1'b1;
                        end else begin
                            q_d = shift_nxt;
                        end
`endif
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            q_q      <= SEED;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
        end
    end

    assign q      = q_q;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign valid  = busy & en;
    assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Directed bench for lfsr_pattern_gen: expected patterns queued by stimulus, checked by a monitor.
module tb_lfsr_pattern_gen;

    localparam int unsigned W  = 3;
    localparam int unsigned CW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Init = 1'b0;
    logic [W-1:0]  seed_in = '0;
    logic          start = 1'b0;
    logic [CW-1:0] pat_count = '0;
    logic          en = 1'b0;
`ifdef LFSR_MISR_EN
    logic [W-1:0]  data_in = '0;
`endif
    logic [W-1:0]  q;
    logic          valid, busy, done, lockup;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    lfsr_pattern_gen dut (
        .CLK       (CLK),
        .RST       (RST),
        .Init      (Init),
        .seed_in   (seed_in),
        .start     (start),
        .pat_count (pat_count),
        .en        (en),
`ifdef LFSR_MISR_EN
        .data_in   (data_in),
`endif
        .q         (q),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .lockup    (lockup)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20) begin
            cyc();
            n++;
        end
        chk({name, "_done_timeout"}, 32'(done), 32'd1);
    endtask

    // Monitor: every valid cycle must match the next queued pattern.
    always @(negedge CLK) begin
        if (!RST && valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(q), 32'hFFFF_FFFF);
            end else begin
                chk("pattern", 32'(q), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_q", 32'(q), 32'h7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lockup", 32'(lockup), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cyc();

        // Full 7-pattern run from seed 001
        Init = 1'b1; seed_in = 3'b001;
        cyc();
        Init = 1'b0;
        start = 1'b1; pat_count = 8'd7; en = 1'b1;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b101);
        exp_q.push_back(3'b011); exp_q.push_back(3'b111); exp_q.push_back(3'b110);
        exp_q.push_back(3'b100);
        cyc();
        start = 1'b0;
        chk("run7_busy", 32'(busy), 32'd1);
        wait_done("run7");
        chk("run7_q_end", 32'(q), 32'h1);
        chk("run7_drained", 32'(exp_q.size()), 32'd0);

        // en gating: 3 patterns over 5 RUN cycles, continuing from DONE
        start = 1'b1; pat_count = 8'd3; en = 1'b0;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b101);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = (i % 2 == 0);
            chk("gate_busy", 32'(busy), 32'd1);
            cyc();
        end
        en = 1'b0;
        chk("gate_done", 32'(done), 32'd1);
        chk("gate_q_end", 32'(q), 32'h3);
        chk("gate_drained", 32'(exp_q.size()), 32'd0);

        // Zero seed: lock-up recovery to SEED
        Init = 1'b1; seed_in = 3'b000;
        cyc();
        Init = 1'b0;
        chk("zero_idle_q", 32'(q), 32'h0);
        start = 1'b1; pat_count = 8'd2; en = 1'b1;
        exp_q.push_back(3'b000); exp_q.push_back(3'b111);
        cyc();
        start = 1'b0;
        chk("zero_lockup_pre", 32'(lockup), 32'd0);
        cyc();
        chk("zero_recover_q", 32'(q), 32'h7);
        chk("zero_lockup_set", 32'(lockup), 32'd1);
        cyc();
        en = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_lockup_sticky", 32'(lockup), 32'd1);
        chk("zero_q_end", 32'(q), 32'h6);
        chk("zero_drained", 32'(exp_q.size()), 32'd0);
        start = 1'b1; pat_count = 8'd0;
        cyc();
        start = 1'b0;
        chk("restart_clears_lockup", 32'(lockup), 32'd0);

        // pat_count = 0 from IDLE: DONE without valid
        Init = 1'b1; seed_in = 3'b101;
        cyc();
        Init = 1'b0;
        start = 1'b1; pat_count = 8'd0; en = 1'b1;
        cyc();
        start = 1'b0;
        chk("pc0_done", 32'(done), 32'd1);
        chk("pc0_busy", 32'(busy), 32'd0);
        chk("pc0_q", 32'(q), 32'h5);
        en = 1'b0;

        // Init and start together: Init wins
        Init = 1'b1; seed_in = 3'b011; start = 1'b1; pat_count = 8'd5;
        cyc();
        Init = 1'b0; start = 1'b0;
        chk("init_prio_busy", 32'(busy), 32'd0);
        chk("init_prio_done", 32'(done), 32'd0);
        chk("init_prio_q", 32'(q), 32'h3);
        cyc();
        chk("init_prio_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        start = 1'b1; pat_count = 8'd5; en = 1'b1;
        exp_q.push_back(3'b011);
        cyc();
        start = 1'b0;
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("arst_q", 32'(q), 32'h7);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_lockup", 32'(lockup), 32'd0);
        en = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        cyc();
        chk("arst_release_idle", 32'({busy, done}), 32'd0);
        chk("arst_release_q", 32'(q), 32'h7);
        chk("arst_drained", 32'(exp_q.size()), 32'd0);

`ifdef LFSR_MISR_EN
        // MISR compaction from zero seed
        Init = 1'b1; seed_in = 3'b000;
        cyc();
        Init = 1'b0;
        start = 1'b1; pat_count = 8'd3; en = 1'b1;
        exp_q.push_back(3'b000); exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        cyc();
        start = 1'b0;
        data_in = 3'b001;
        cyc();
        data_in = 3'b000;
        chk("misr_q1", 32'(q), 32'h1);
        cyc();
        chk("misr_q2", 32'(q), 32'h2);
        cyc();
        en = 1'b0;
        chk("misr_q3", 32'(q), 32'h5);
        chk("misr_done", 32'(done), 32'd1);
        chk("misr_lockup", 32'(lockup), 32'd0);
        chk("misr_drained", 32'(exp_q.size()), 32'd0);
`endif

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
